// File: rtl/ctrl_mc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ctrl_mc : multi-cycle RV32I control sequencer (FETCH/DECODE/EXEC/MEM/WB)
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module ctrl_mc #(
  parameter int MEM_LAT  = 1,
  parameter int USE_RDY  = 0,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          opcode,
  input  logic [2:0]          func3,
  input  logic [6:0]          func7,
  input  logic                b,
  input  logic                mem_rdy,
  input  logic                stall,
  output logic                ir_en,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                reg_wr,
  output logic                we,
  output logic                mem_sel,
  output logic [1:0]          pc_sel,
  output logic                pc_en,
  output logic                illegal,
  output logic [2:0]          state
);

  localparam logic [4:0] c_OP_LOAD   = 5'b00000;
  localparam logic [4:0] c_OP_IMM    = 5'b00100;
  localparam logic [4:0] c_OP_AUIPC  = 5'b00101;
  localparam logic [4:0] c_OP_STORE  = 5'b01000;
  localparam logic [4:0] c_OP_OP     = 5'b01100;
  localparam logic [4:0] c_OP_LUI    = 5'b01101;
  localparam logic [4:0] c_OP_BRANCH = 5'b11000;
  localparam logic [4:0] c_OP_JALR   = 5'b11001;
  localparam logic [4:0] c_OP_JAL    = 5'b11011;

  localparam logic [ALU_OP_W-1:0] c_ALU_ADD   = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] c_ALU_SUB   = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] c_ALU_SLT   = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] c_ALU_SLTU  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] c_ALU_XOR   = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] c_ALU_OR    = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] c_ALU_AND   = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] c_ALU_SLL   = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] c_ALU_SRL   = ALU_OP_W'(8);
  localparam logic [ALU_OP_W-1:0] c_ALU_SRA   = ALU_OP_W'(9);
  localparam logic [ALU_OP_W-1:0] c_ALU_PASSB = ALU_OP_W'(10);

  localparam int                 c_CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MEM_LAT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(MEM_LAT);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t                r_state;
  logic [ALU_OP_W-1:0]   r_alu_op;
  logic                  r_illegal;
  logic [c_CNT_W-1:0]    r_cnt;

  logic                  w_is_load;
  logic                  w_is_store;
  logic                  w_is_branch;
  logic                  w_is_jal;
  logic                  w_is_jalr;
  logic                  w_is_arith;
  logic                  w_legal;
  logic                  w_mem_done;
  logic                  w_run;
  logic [ALU_OP_W-1:0]   w_alu_dec;
  logic                  w_unused;

  assign w_is_load   = (opcode == c_OP_LOAD);
  assign w_is_store  = (opcode == c_OP_STORE);
  assign w_is_branch = (opcode == c_OP_BRANCH);
  assign w_is_jal    = (opcode == c_OP_JAL);
  assign w_is_jalr   = (opcode == c_OP_JALR);
  assign w_is_arith  = (opcode == c_OP_OP) || (opcode == c_OP_IMM);
  assign w_legal     = opcode inside {c_OP_LOAD, c_OP_IMM, c_OP_AUIPC, c_OP_STORE, c_OP_OP,
                                      c_OP_LUI, c_OP_BRANCH, c_OP_JALR, c_OP_JAL};
  assign w_mem_done  = (USE_RDY != 0) ? mem_rdy : (r_cnt == c_CNT_LAST);
  assign w_run       = rst & ~stall;
  assign w_unused    = ^{func7[6], func7[4:0]};

  always_comb begin
    w_alu_dec = c_ALU_ADD;
    if (opcode == c_OP_LUI) begin
      w_alu_dec = c_ALU_PASSB;
    end else if (w_is_arith) begin
      case (func3)
        3'b000:  w_alu_dec = ((opcode == c_OP_OP) && func7[5]) ? c_ALU_SUB : c_ALU_ADD;
        3'b001:  w_alu_dec = c_ALU_SLL;
        3'b010:  w_alu_dec = c_ALU_SLT;
        3'b011:  w_alu_dec = c_ALU_SLTU;
        3'b100:  w_alu_dec = c_ALU_XOR;
        3'b101:  w_alu_dec = func7[5] ? c_ALU_SRA : c_ALU_SRL;
        3'b110:  w_alu_dec = c_ALU_OR;
        default: w_alu_dec = c_ALU_AND;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_FETCH;
      r_alu_op  <= '0;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
    end else if (!stall) begin
      case (r_state)
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          if (w_legal) begin
            r_state  <= S_EXEC;
            r_alu_op <= w_alu_dec;
          end else begin
            r_state   <= S_HALT;
            r_illegal <= 1'b1;
          end
        end
        S_EXEC: begin
          r_cnt <= '0;
          if (w_is_load || w_is_store) r_state <= S_MEM;
          else if (w_is_branch)        r_state <= S_FETCH;
          else                         r_state <= S_WB;
        end
        S_MEM: begin
          // saturate rather than wrap so a long rdy wait cannot alias an early exit
          if (r_cnt != c_CNT_MAX) r_cnt <= r_cnt + c_CNT_ONE;
          if (w_mem_done) r_state <= w_is_store ? S_FETCH : S_WB;
        end
        S_WB:    r_state <= S_FETCH;
        default: r_state <= S_HALT;
      endcase
    end
  end

  // Enables decode the registered state so stall and async reset gate them in the same cycle.
  always_comb begin
    ir_en   = 1'b0;
    reg_wr  = 1'b0;
    we      = 1'b0;
    pc_en   = 1'b0;
    pc_sel  = 2'b00;
    mem_sel = (r_state == S_MEM);
    case (r_state)
      S_FETCH: ir_en = w_run;
      S_EXEC: begin
        if (w_is_branch) begin
          pc_en  = w_run;
          pc_sel = b ? 2'b01 : 2'b00;
        end
      end
      S_MEM: begin
        we    = w_run & w_is_store;
        pc_en = w_run & w_is_store & w_mem_done;
      end
      S_WB: begin
        reg_wr = w_run;
        pc_en  = w_run;
        pc_sel = w_is_jal ? 2'b01 : (w_is_jalr ? 2'b10 : 2'b00);
      end
      default: ;
    endcase
  end

  assign alu_op  = r_alu_op;
  assign illegal = r_illegal;
  assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_mc.sv
`default_nettype none
// tb_ctrl_mc: two instances (fixed latency 3, rdy handshake) checked each cycle against an
// instruction-timeline model, plus literal expectations for the directed scenarios.
module tb_ctrl_mc;

  localparam int c_LAT   = 3;
  localparam int c_NRAND = 4000;

  localparam logic [4:0] c_LOAD   = 5'b00000;
  localparam logic [4:0] c_OPIMM  = 5'b00100;
  localparam logic [4:0] c_STORE  = 5'b01000;
  localparam logic [4:0] c_OP     = 5'b01100;
  localparam logic [4:0] c_BRANCH = 5'b11000;
  localparam logic [4:0] c_JALR   = 5'b11001;
  localparam logic [4:0] c_JAL    = 5'b11011;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] opc [2];
  logic [2:0] f3  [2];
  logic [6:0] f7  [2];
  logic       bb  [2];
  logic       rdy [2];
  logic       stl [2];
  logic       ir_en [2];
  logic       reg_wr [2];
  logic       we [2];
  logic       mem_sel [2];
  logic       pc_en [2];
  logic       illegal [2];
  logic [3:0] alu_op [2];
  logic [1:0] pc_sel [2];
  logic [2:0] state [2];

  logic [4:0] legal_ops [9] = '{5'b00000, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
                                5'b01101, 5'b11000, 5'b11001, 5'b11011};

  int checks = 0;
  int errors = 0;

  // model: progress index within the current instruction, halt flag, expected alu_op
  int         p      [2];
  bit         halted [2];
  bit         m_ill  [2];
  logic [3:0] m_alu  [2];

  int rec_ir [16];
  int rec_pe [16];
  int rec_rw [16];
  int rec_we [16];
  int rec_ms [16];
  int rec_ps [16];
  int rec_alu[16];
  int rec_st [16];
  int rec_ill[16];

  always #5 clk = ~clk;

  ctrl_mc #(.MEM_LAT(c_LAT), .USE_RDY(0), .ALU_OP_W(4)) u_lat (
    .clk(clk), .rst(rst), .opcode(opc[0]), .func3(f3[0]), .func7(f7[0]), .b(bb[0]),
    .mem_rdy(rdy[0]), .stall(stl[0]), .ir_en(ir_en[0]), .alu_op(alu_op[0]),
    .reg_wr(reg_wr[0]), .we(we[0]), .mem_sel(mem_sel[0]), .pc_sel(pc_sel[0]),
    .pc_en(pc_en[0]), .illegal(illegal[0]), .state(state[0])
  );

  ctrl_mc #(.MEM_LAT(1), .USE_RDY(1), .ALU_OP_W(4)) u_rdy (
    .clk(clk), .rst(rst), .opcode(opc[1]), .func3(f3[1]), .func7(f7[1]), .b(bb[1]),
    .mem_rdy(rdy[1]), .stall(stl[1]), .ir_en(ir_en[1]), .alu_op(alu_op[1]),
    .reg_wr(reg_wr[1]), .we(we[1]), .mem_sel(mem_sel[1]), .pc_sel(pc_sel[1]),
    .pc_en(pc_en[1]), .illegal(illegal[1]), .state(state[1])
  );

  task automatic chk(input string name, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d, expected %0d at %0t", name, d, act, exp, $time);
    end
  endtask

  function automatic bit is_mem(input logic [4:0] o);
    return (o == c_LOAD) || (o == c_STORE);
  endfunction

  function automatic bit is_legal(input logic [4:0] o);
    for (int i = 0; i < 9; i++) if (legal_ops[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_alu(input logic [4:0] o, input logic [2:0] a, input logic [6:0] c);
    logic [3:0] base [8];
    base = '{4'd0, 4'd7, 4'd2, 4'd3, 4'd4, 4'd8, 4'd5, 4'd6};
    if (o == 5'b01101) return 4'd10;
    if ((o != c_OP) && (o != c_OPIMM)) return 4'd0;
    if ((a == 3'b101) && c[5]) return 4'd9;
    if ((a == 3'b000) && c[5] && (o == c_OP)) return 4'd1;
    return base[a];
  endfunction

  // 0 fetch, 1 decode, 2 exec, 3 mem, 4 writeback, 5 halted
  function automatic int phase(input int d);
    if (halted[d]) return 5;
    if (p[d] < 3) return p[d];
    if (!is_mem(opc[d])) return 4;
    if (d == 0) return (p[d] < 3 + c_LAT) ? 3 : 4;
    return (p[d] == 3) ? 3 : 4;
  endfunction

  function automatic bit mem_exit(input int d);
    return (d == 0) ? (p[d] == 2 + c_LAT) : rdy[d];
  endfunction

  function automatic bit last_cycle(input int d);
    int ph;
    ph = phase(d);
    if (ph == 2) return opc[d] == c_BRANCH;
    if (ph == 4) return 1'b1;
    if (ph == 3) return (opc[d] == c_STORE) && mem_exit(d);
    return 1'b0;
  endfunction

  function automatic int exp_pc_en(input int d);
    int ph;
    ph = phase(d);
    if (stl[d] || ph == 5) return 0;
    return int'((ph == 2 && opc[d] == c_BRANCH) || ph == 4 ||
                (ph == 3 && opc[d] == c_STORE && mem_exit(d)));
  endfunction

  function automatic int exp_pc_sel(input int d);
    int ph;
    ph = phase(d);
    if (ph == 2) return bb[d] ? 1 : 0;
    if (ph == 4) return (opc[d] == c_JAL) ? 1 : ((opc[d] == c_JALR) ? 2 : 0);
    return 0;
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        chk("rst_state", d, int'(state[d]), 0);
        chk("rst_alu", d, int'(alu_op[d]), 0);
        chk("rst_illegal", d, int'(illegal[d]), 0);
        chk("rst_enables", d, int'({ir_en[d], reg_wr[d], we[d], pc_en[d], mem_sel[d]}), 0);
        p[d]      <= 0;
        halted[d] <= 1'b0;
        m_ill[d]  <= 1'b0;
        m_alu[d]  <= 4'd0;
      end else begin
        chk("state", d, int'(state[d]), phase(d));
        chk("ir_en", d, int'(ir_en[d]), int'(phase(d) == 0 && !stl[d]));
        chk("reg_wr", d, int'(reg_wr[d]), int'(phase(d) == 4 && !stl[d]));
        chk("we", d, int'(we[d]), int'(phase(d) == 3 && opc[d] == c_STORE && !stl[d]));
        chk("mem_sel", d, int'(mem_sel[d]), int'(phase(d) == 3));
        chk("pc_en", d, int'(pc_en[d]), exp_pc_en(d));
        if (exp_pc_en(d) != 0) chk("pc_sel", d, int'(pc_sel[d]), exp_pc_sel(d));
        chk("alu_op", d, int'(alu_op[d]), int'(m_alu[d]));
        chk("illegal", d, int'(illegal[d]), int'(m_ill[d]));
        if (!stl[d] && phase(d) != 5) begin
          if (phase(d) == 1 && !is_legal(opc[d])) begin
            halted[d] <= 1'b1;
            m_ill[d]  <= 1'b1;
          end else begin
            if (phase(d) == 1) m_alu[d] <= exp_alu(opc[d], f3[d], f7[d]);
            if (last_cycle(d))                          p[d] <= 0;
            else if (d == 1 && phase(d) == 3 && !rdy[d]) p[d] <= p[d];
            else                                        p[d] <= p[d] + 1;
          end
        end
      end
    end
  end

  // Runs one instruction on dut d (other dut stalled), recording outputs for cycles 1..n.
  task automatic run_lit(input int d, input logic [4:0] o, input logic [2:0] a,
                         input logic [6:0] c, input logic bv, input int n);
    opc[d] = o; f3[d] = a; f7[d] = c; bb[d] = bv; stl[d] = 1'b0; stl[1-d] = 1'b1; rdy[d] = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      rec_ir[k]  = int'(ir_en[d]);
      rec_pe[k]  = int'(pc_en[d]);
      rec_rw[k]  = int'(reg_wr[d]);
      rec_we[k]  = int'(we[d]);
      rec_ms[k]  = int'(mem_sel[d]);
      rec_ps[k]  = int'(pc_sel[d]);
      rec_alu[k] = int'(alu_op[d]);
      rec_st[k]  = int'(state[d]);
      rec_ill[k] = int'(illegal[d]);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      opc[d] = c_OP; f3[d] = 3'b000; f7[d] = 7'b0; bb[d] = 1'b0; rdy[d] = 1'b0; stl[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    run_lit(0, c_OP, 3'b000, 7'b0100000, 1'b0, 4);
    chk("t1_ir_c1", 0, rec_ir[1], 1);
    chk("t1_alu_sub", 0, rec_alu[3], 1);
    chk("t1_rw_c3", 0, rec_rw[3], 0);
    chk("t1_rw_c4", 0, rec_rw[4], 1);
    chk("t1_pe_c4", 0, rec_pe[4], 1);
    chk("t1_ps_c4", 0, rec_ps[4], 0);

    run_lit(0, c_OP, 3'b101, 7'b0000000, 1'b0, 4);
    chk("t2_srl", 0, rec_alu[3], 8);
    run_lit(0, c_OP, 3'b101, 7'b0100000, 1'b0, 4);
    chk("t2_sra", 0, rec_alu[3], 9);
    run_lit(0, c_OPIMM, 3'b000, 7'b0100000, 1'b0, 4);
    chk("t2_addi", 0, rec_alu[3], 0);

    run_lit(0, c_BRANCH, 3'b000, 7'b0, 1'b1, 3);
    chk("t5_bt_pe", 0, rec_pe[3], 1);
    chk("t5_bt_ps", 0, rec_ps[3], 1);
    run_lit(0, c_BRANCH, 3'b000, 7'b0, 1'b0, 3);
    chk("t5_bn_pe", 0, rec_pe[3], 1);
    chk("t5_bn_ps", 0, rec_ps[3], 0);
    run_lit(0, c_JALR, 3'b000, 7'b0, 1'b0, 4);
    chk("t5_jalr_ps", 0, rec_ps[4], 2);
    chk("t5_jalr_rw", 0, rec_rw[4], 1);

    run_lit(0, c_LOAD, 3'b010, 7'b0, 1'b0, 7);
    chk("t3_ld_ms3", 0, rec_ms[3], 0);
    chk("t3_ld_ms456", 0, rec_ms[4] + rec_ms[5] + rec_ms[6], 3);
    chk("t3_ld_ms7", 0, rec_ms[7], 0);
    chk("t3_ld_rw6", 0, rec_rw[6], 0);
    chk("t3_ld_rw7", 0, rec_rw[7], 1);
    run_lit(0, c_STORE, 3'b010, 7'b0, 1'b0, 6);
    chk("t3_st_we456", 0, rec_we[4] + rec_we[5] + rec_we[6], 3);
    chk("t3_st_pe5", 0, rec_pe[5], 0);
    chk("t3_st_pe6", 0, rec_pe[6], 1);
    chk("t3_st_rw", 0, rec_rw[1] + rec_rw[2] + rec_rw[3] + rec_rw[4] + rec_rw[5] + rec_rw[6], 0);

    // rdy handshake: rdy rises after 5 MEM cycles, first rdy cycle is stalled
    opc[1] = c_STORE; stl[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      rdy[1] = (k == 9 || k == 10);
      stl[1] = (k == 9);
      @(negedge clk);
      rec_we[k] = int'(we[1]);
      rec_pe[k] = int'(pc_en[1]);
      rec_ms[k] = int'(mem_sel[1]);
      @(posedge clk); #1;
    end
    rdy[1] = 1'b0; stl[1] = 1'b0;
    chk("t4_we4_8", 1, rec_we[4] + rec_we[5] + rec_we[6] + rec_we[7] + rec_we[8], 5);
    chk("t4_we9", 1, rec_we[9], 0);
    chk("t4_we10", 1, rec_we[10], 1);
    chk("t4_pe9", 1, rec_pe[9], 0);
    chk("t4_pe10", 1, rec_pe[10], 1);
    chk("t4_ms10", 1, rec_ms[10], 1);
    chk("t4_fetch", 1, int'(state[1]), 0);

    for (int cyc = 0; cyc < c_NRAND; cyc++) begin
      for (int d = 0; d < 2; d++) begin
        stl[d] = ($urandom_range(0, 4) == 0);
        rdy[d] = ($urandom_range(0, 2) == 0);
        bb[d]  = 1'($urandom_range(0, 1));
        if (p[d] == 0) begin
          opc[d] = legal_ops[$urandom_range(0, 8)];
          f3[d]  = 3'($urandom_range(0, 7));
          f7[d]  = ($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'($urandom_range(0, 127));
        end
      end
      @(posedge clk); #1;
    end

    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin stl[d] = 1'b0; rdy[d] = 1'b0; end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    run_lit(0, 5'b11111, 3'b000, 7'b0, 1'b0, 6);
    chk("t6_ir_c1", 0, rec_ir[1], 1);
    chk("t6_halt", 0, rec_st[3], 5);
    chk("t6_ill", 0, rec_ill[3], 1);
    chk("t6_no_ir", 0, rec_ir[3] + rec_ir[4] + rec_ir[5] + rec_ir[6], 0);
    chk("t6_halt_c6", 0, rec_st[6], 5);

    run_lit(1, c_STORE, 3'b010, 7'b0, 1'b0, 4);
    chk("t6_we_pre", 1, int'(we[1]), 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_state", 1, int'(state[1]), 0);
    chk("t6_async_we", 1, int'(we[1]), 0);
    chk("t6_async_ms", 1, int'(mem_sel[1]), 0);
    chk("t6_async_ill", 0, int'(illegal[0]), 0);
    @(posedge clk); #1 rst = 1'b1;
    stl[0] = 1'b0; stl[1] = 1'b0; opc[0] = c_OP; opc[1] = c_OP;
    repeat (4) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
